fetch_stage: RTL and testbench

//  Instruction fetch stage directly upstream of the IF/ID latch. Owns the PC and drives the icache request.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the fetch sequencer states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;

  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the icache and feeds IF/ID.
// Redirects that land during an icache miss are parked until the miss returns.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = 32'h0000_0000,
  parameter int unsigned PC_INC  = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  redirect_en,
  input  word_t redirect_pc,
  input  logic  stall,
  input  logic  halt,
  output word_t instr_out,
  output word_t npc_out,
  output logic  flush_out,
  output logic  halted
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n;
  word_t        pend_pc, pend_pc_n;
  word_t        npc;
  word_t        tgt;

  assign npc = pc + word_t'(PC_INC);
  assign tgt = align_word(redirect_pc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      pc      <= PC_INIT;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_pc_n;
    end
  end

  // Priority: halt > redirect > stall > sequential advance.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    unique case (state)
      RUN: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect_en) begin
          if (ihit) begin
            pc_n = tgt;
          end else begin
            pend_pc_n = tgt;
            state_n   = REDIR_PEND;
          end
        end else if (ihit && !stall) begin
          pc_n = npc;
        end
      end
      REDIR_PEND: begin
        if (halt) begin
          state_n = HALTED;
        end else begin
          // Latest redirect wins, including one arriving with the ihit.
          if (redirect_en) pend_pc_n = tgt;
          if (ihit) begin
            pc_n    = redirect_en ? tgt : pend_pc;
            state_n = RUN;
          end
        end
      end
      HALTED:  state_n = HALTED;
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    imemaddr  = pc;
    instr_out = imemload;
    npc_out   = npc;
    imemREN   = (state != HALTED);
    halted    = (state == HALTED);
    flush_out = (state == REDIR_PEND) || ((state == RUN) && redirect_en);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus a few hand-written sequences.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST, ihit, redirect_en, stall, halt;
  word_t imemload, redirect_pc;
  logic  imemREN, flush_out, halted;
  word_t imemaddr, instr_out, npc_out;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.PC_INIT(32'h0000_0000), .PC_INC(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall), .halt(halt),
    .instr_out(instr_out), .npc_out(npc_out),
    .flush_out(flush_out), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  rst, ihit, stall, red, halt;
    word_t rpc;
    word_t e_addr;
    logic  e_flush, e_ren, e_halted;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic ih, input logic st,
                              input logic rd, input word_t rpc, input logic hl,
                              input word_t ea, input logic ef, input logic er,
                              input logic eh);
    vec_t v;
    v.rst = rst; v.ihit = ih; v.stall = st; v.red = rd; v.rpc = rpc; v.halt = hl;
    v.e_addr = ea; v.e_flush = ef; v.e_ren = er; v.e_halted = eh;
    return v;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ih, input logic st,
                       input logic rd, input word_t rpc, input logic hl);
    RST = rst; ihit = ih; stall = st; redirect_en = rd; redirect_pc = rpc; halt = hl;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    imemload = 32'h0;

    // Reset: held for two edges, outputs checked while RST is still high.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_addr",   imemaddr,          32'h0);
    check("rst_ren",    word_t'(imemREN),  32'h1);
    check("rst_halted", word_t'(halted),   32'h0);
    check("rst_flush",  word_t'(flush_out), 32'h1);
    check("rst_npc",    npc_out,           32'h4);

    // Sequential fetch
    vq.push_back(mk(0,1,0,0,0,0, 32'h0,   0,1,0));
    vq.push_back(mk(0,1,0,0,0,0, 32'h4,   0,1,0));
    vq.push_back(mk(0,1,0,0,0,0, 32'h8,   0,1,0));
    vq.push_back(mk(0,1,0,0,0,0, 32'hC,   0,1,0));
    // Stall holds PC for three cycles
    vq.push_back(mk(0,1,1,0,0,0, 32'h10,  0,1,0));
    vq.push_back(mk(0,1,1,0,0,0, 32'h10,  0,1,0));
    vq.push_back(mk(0,1,1,0,0,0, 32'h10,  0,1,0));
    vq.push_back(mk(0,1,0,0,0,0, 32'h10,  0,1,0));
    // Redirect with hit: low bits of target forced to zero
    vq.push_back(mk(0,1,0,1,32'h20,0,  32'h14,  1,1,0));
    vq.push_back(mk(0,1,0,1,32'h103,0, 32'h20,  1,1,0));
    vq.push_back(mk(0,1,0,1,32'h40,0,  32'h100, 1,1,0));
    // Redirect during a miss, hit arrives three cycles later
    vq.push_back(mk(0,0,0,1,32'h200,0, 32'h40,  1,1,0));
    vq.push_back(mk(0,0,0,0,0,0,       32'h40,  1,1,0));
    vq.push_back(mk(0,0,0,0,0,0,       32'h40,  1,1,0));
    vq.push_back(mk(0,1,0,0,0,0,       32'h40,  1,1,0));
    vq.push_back(mk(0,1,0,0,0,0,       32'h200, 0,1,0));
    // Latest redirect wins on the ihit cycle
    vq.push_back(mk(0,0,0,1,32'h300,0, 32'h204, 1,1,0));
    vq.push_back(mk(0,1,0,1,32'h401,0, 32'h204, 1,1,0));
    vq.push_back(mk(0,0,0,0,0,0,       32'h400, 0,1,0));
    // Stall ignored while a redirect is parked
    vq.push_back(mk(0,0,0,1,32'h500,0, 32'h400, 1,1,0));
    vq.push_back(mk(0,1,1,0,0,0,       32'h400, 1,1,0));
    // Halt beats a same-cycle redirect; halted is absorbing
    vq.push_back(mk(0,1,0,1,32'h600,1, 32'h500, 1,1,0));
    vq.push_back(mk(0,1,0,1,32'h700,0, 32'h500, 0,0,1));
    vq.push_back(mk(1,1,1,1,32'h700,0, 32'h500, 0,0,1));
    vq.push_back(mk(0,1,0,1,32'hFFFF_FFFF,0, 32'h0, 1,1,0));
    // Address wrap
    vq.push_back(mk(0,1,0,0,0,0,       32'hFFFF_FFFC, 0,1,0));
    vq.push_back(mk(0,1,0,0,0,0,       32'h0,   0,1,0));
    // Reset while a redirect is parked discards it
    vq.push_back(mk(0,0,0,1,32'h800,0, 32'h4,   1,1,0));
    vq.push_back(mk(1,0,0,0,0,0,       32'h4,   1,1,0));
    vq.push_back(mk(0,1,0,0,0,0,       32'h0,   0,1,0));
    // Halt while a redirect is parked
    vq.push_back(mk(0,0,0,1,32'h900,0, 32'h4,   1,1,0));
    vq.push_back(mk(0,1,0,0,0,1,       32'h4,   1,1,0));
    vq.push_back(mk(0,1,0,0,0,0,       32'h4,   0,0,1));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].ihit, vq[i].stall, vq[i].red, vq[i].rpc, vq[i].halt);
      imemload = 32'hA5A5_0000 ^ word_t'(i * 32'h0101_0007);
      #1;
      check($sformatf("v%0d_addr", i),   imemaddr,             vq[i].e_addr);
      check($sformatf("v%0d_npc", i),    npc_out,              vq[i].e_addr + 32'd4);
      check($sformatf("v%0d_flush", i),  word_t'(flush_out),   word_t'(vq[i].e_flush));
      check($sformatf("v%0d_ren", i),    word_t'(imemREN),     word_t'(vq[i].e_ren));
      check($sformatf("v%0d_halted", i), word_t'(halted),      word_t'(vq[i].e_halted));
      check($sformatf("v%0d_instr", i),  instr_out,            imemload);
      @(negedge CLK);
    end

    // Halted stays put under random redirect/stall/ihit traffic
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
            word_t'($urandom), 1'b0);
      @(negedge CLK);
      check($sformatf("hold%0d_addr", k), imemaddr,         32'h4);
      check($sformatf("hold%0d_ren", k),  word_t'(imemREN), 32'h0);
    end

    // Reset out of HALTED restores fetching from PC_INIT
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("rel_addr",   imemaddr,         32'h0);
    check("rel_ren",    word_t'(imemREN), 32'h1);
    check("rel_halted", word_t'(halted),  32'h0);
    @(negedge CLK);
    check("rel_next",   imemaddr,         32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
